board_plot_scanner: RTL and testbench

- Downstream display stage for the board RAM.
- Walks all 64 cells in row-major order and drives the board read port (rd_x, rd_y → q).
- Converts each cell into one paced plot request (x_plot, y_plot, select, enable) for the VGA cell plotter.
- Replaces free-running, latch-based plot logic with a clocked FSM that has explicit stall and handshake rules.

---
 rtl/othello_pkg.sv | 27 ++
 rtl/plot_pace_counter.sv | 28 ++
 rtl/board_plot_scanner.sv | 171 +++++++++++++++++
 tb/tb_board_plot_scanner.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// othello_pkg: shared cell codes, board size, default plot geometry and the
// state encoding of the board plot scanner.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_HL    = 2'b01;
  localparam logic [1:0] CELL_SIDE0 = 2'b10;
  localparam logic [1:0] CELL_SIDE1 = 2'b11;

  localparam int BOARD_DIM = 8;

  localparam int DEF_ORIGIN_X = 9;
  localparam int DEF_ORIGIN_Y = 9;
  localparam int DEF_PITCH    = 13;
  localparam int DEF_PACE     = 19999;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_SAMPLE    = 3'd2,
    S_PACE_WAIT = 3'd3,
    S_PLOT      = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } scan_state_t;

endpackage

// File: rtl/plot_pace_counter.sv
// plot_pace_counter: loadable down-counter with a zero flag. It holds at zero
// rather than wrapping, so a stray decrement can never restart a long wait.
module plot_pace_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/board_plot_scanner.sv
// board_plot_scanner: walks the 64 board cells in row-major order, reads each
// one through the board RAM read port and issues one paced plot request per
// cell to the VGA cell plotter. Cell pixel coordinates are kept by
// incremental addition, so no multipliers are needed.
// Optional build macro CURSOR_HL_EN adds cur_x/cur_y inputs; an empty cell
// under the cursor is then drawn with the highlight code.
module board_plot_scanner
  import othello_pkg::*;
#(
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int PITCH    = DEF_PITCH,
  parameter int PACE     = DEF_PACE
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       en_plot,
  input  logic       board_busy,
  input  logic [1:0] q,
  input  logic       plot_ready,
`ifdef CURSOR_HL_EN
  input  logic [2:0] cur_x,
  input  logic [2:0] cur_y,
`endif
  output logic [2:0] rd_x,
  output logic [2:0] rd_y,
  output logic [7:0] x_plot,
  output logic [6:0] y_plot,
  output logic [1:0] select,
  output logic       enable,
  output logic       frame_done,
  output logic       busy
);

  localparam int         CW       = $clog2(PACE + 1);
  localparam logic [7:0] OX       = 8'(ORIGIN_X);
  localparam logic [6:0] OY       = 7'(ORIGIN_Y);
  localparam logic [7:0] STEP_X   = 8'(PITCH);
  localparam logic [6:0] STEP_Y   = 7'(PITCH);
  localparam logic [5:0] LAST_IDX = 6'(BOARD_DIM * BOARD_DIM - 1);
  localparam logic [2:0] LAST_COL = 3'(BOARD_DIM - 1);

  scan_state_t   state;
  scan_state_t   state_next;
  logic [5:0]    idx;
  logic [7:0]    cell_px;
  logic [6:0]    cell_py;
  logic [1:0]    sample_select;
  logic          pace_load;
  logic          pace_dec;
  logic          pace_zero;
  logic [CW-1:0] pace_count;

  plot_pace_counter #(
    .WIDTH(CW)
  ) u_pace (
    .clock      (clock),
    .reset      (resetn),
    .load       (pace_load),
    .load_value (CW'(PACE)),
    .dec        (pace_dec),
    .count      (pace_count),
    .zero       (pace_zero)
  );

  assign rd_x = idx[2:0];
  assign rd_y = idx[5:3];

  // Cell code captured in SAMPLE: q as-is, or the highlight code for an empty
  // cell under the cursor when the cursor feature is built in.
  always_comb begin
    sample_select = q;
`ifdef CURSOR_HL_EN
    if ((rd_x == cur_x) && (rd_y == cur_y) && (q[1] == 1'b0)) begin
      sample_select = CELL_HL;
    end
`endif
  end

  // Next-state logic and pace counter control. The pace wait leaves on the
  // cycle the counter reaches zero, giving exactly PACE wait cycles per cell.
  always_comb begin
    state_next = state;
    pace_load  = 1'b0;
    pace_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en_plot) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (!board_busy) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        pace_load  = 1'b1;
        state_next = S_PACE_WAIT;
      end
      S_PACE_WAIT: begin
        pace_dec = 1'b1;
        if (pace_zero || (pace_count == CW'(1))) state_next = S_PLOT;
      end
      S_PLOT: begin
        if (plot_ready) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (idx == LAST_IDX) state_next = S_DONE;
        else if (en_plot)    state_next = S_ADDR;
        else                 state_next = S_IDLE;
      end
      S_DONE: begin
        state_next = en_plot ? S_ADDR : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (resetn) state <= S_IDLE;
    else        state <= state_next;
  end

  // Registered outputs, cell index and incremental pixel coordinates.
  always_ff @(posedge clock) begin
    if (resetn) begin
      idx        <= '0;
      cell_px    <= OX;
      cell_py    <= OY;
      x_plot     <= OX;
      y_plot     <= OY;
      select     <= CELL_EMPTY;
      enable     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      enable     <= (state == S_PLOT) && plot_ready;
      frame_done <= (state == S_NEXT) && (idx == LAST_IDX);
      busy       <= (state_next != S_IDLE);
      case (state)
        S_SAMPLE: begin
          select <= sample_select;
          x_plot <= cell_px;
          y_plot <= cell_py;
        end
        S_NEXT: begin
          if (idx != LAST_IDX) begin
            if (en_plot) begin
              idx <= idx + 6'd1;
              if (idx[2:0] == LAST_COL) begin
                cell_px <= OX;
                cell_py <= cell_py + STEP_Y;
              end else begin
                cell_px <= cell_px + STEP_X;
              end
            end else begin
              idx     <= '0;
              cell_px <= OX;
              cell_py <= OY;
            end
          end
        end
        S_DONE: begin
          idx     <= '0;
          cell_px <= OX;
          cell_py <= OY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_plot_scanner.sv
// tb_board_plot_scanner: scoreboard bench for board_plot_scanner with PACE=2.
// Expected plot requests and frame_done pulses are queued when stimulus is
// issued; a negedge monitor pops and compares them as the DUT produces them.
// Build with CURSOR_HL_EN defined to also exercise the cursor highlight.
module tb_board_plot_scanner;

  localparam int PACE = 2;

  typedef struct {
    int cyc;
    int x;
    int y;
    int sel;
  } plot_exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       en_plot;
  logic       board_busy;
  logic [1:0] q;
  logic       plot_ready;
  logic [2:0] rd_x;
  logic [2:0] rd_y;
  logic [7:0] x_plot;
  logic [6:0] y_plot;
  logic [1:0] select;
  logic       enable;
  logic       frame_done;
  logic       busy;
`ifdef CURSOR_HL_EN
  logic [2:0] cx;
  logic [2:0] cy;
`endif

  logic [1:0] board [64];
  plot_exp_t  sb_q[$];
  int         fd_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         en_count = 0;

  board_plot_scanner #(
    .ORIGIN_X (9),
    .ORIGIN_Y (9),
    .PITCH    (13),
    .PACE     (PACE)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .en_plot    (en_plot),
    .board_busy (board_busy),
    .q          (q),
    .plot_ready (plot_ready),
`ifdef CURSOR_HL_EN
    .cur_x      (cx),
    .cur_y      (cy),
`endif
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .x_plot     (x_plot),
    .y_plot     (y_plot),
    .select     (select),
    .enable     (enable),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Cycle counter: value k during the cycle after edge k.
  always @(posedge clock) cyc <= cyc + 1;

  // Combinational board RAM read port.
  assign q = board[{rd_y, rd_x}];

  function automatic int exp_x(int i);
    return 9 + 13 * (i % 8);
  endfunction

  function automatic int exp_y(int i);
    return 9 + 13 * (i / 8);
  endfunction

  function automatic int exp_sel(int i);
`ifdef CURSOR_HL_EN
    if ((i[2:0] == cx) && (i[5:3] == cy) && (board[i][1] == 1'b0)) return 1;
`endif
    return int'(board[i]);
  endfunction

  task automatic init_board();
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
    board[27] = 2'b10;
    board[36] = 2'b10;
    board[28] = 2'b11;
    board[35] = 2'b11;
  endtask

  task automatic applyStimulus(input logic en, input logic bb, input logic pr);
    en_plot    = en;
    board_busy = bb;
    plot_ready = pr;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_rd_x"}, int'(rd_x), 0);
    checkOutput({tag, "_rd_y"}, int'(rd_y), 0);
    checkOutput({tag, "_x_plot"}, int'(x_plot), 9);
    checkOutput({tag, "_y_plot"}, int'(y_plot), 9);
    checkOutput({tag, "_select"}, int'(select), 0);
    checkOutput({tag, "_enable"}, int'(enable), 0);
    checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic push_cell(input int i, input int t);
    plot_exp_t e;
    e.cyc = t;
    e.x   = exp_x(i);
    e.y   = exp_y(i);
    e.sel = exp_sel(i);
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  task automatic start_frame(output int t0);
    @(negedge clock);
    applyStimulus(1'b1, 1'b0, 1'b1);
    t0 = cyc + 1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
  endtask

  task automatic finish_test(input string tag);
    checkOutput({tag, "_plots_left"}, sb_q.size(), 0);
    checkOutput({tag, "_frame_done_left"}, fd_q.size(), 0);
    sb_q.delete();
    fd_q.delete();
  endtask

  // Monitor: pops the scoreboard on every enable and frame_done pulse.
  always @(negedge clock) begin
    plot_exp_t e;
    int        f;
    if (enable) begin
      en_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL plot_unexpected cyc=%0d x=%0d y=%0d select=%0d expected no request",
                 cyc, x_plot, y_plot, select);
      end else begin
        e = sb_q.pop_front();
        if ((cyc != e.cyc) || (int'(x_plot) != e.x) || (int'(y_plot) != e.y) ||
            (int'(select) != e.sel)) begin
          failures++;
          $display("[TB] FAIL plot cyc=%0d x=%0d y=%0d select=%0d expected cyc=%0d x=%0d y=%0d select=%0d",
                   cyc, x_plot, y_plot, select, e.cyc, e.x, e.y, e.sel);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (fd_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL frame_done_unexpected cyc=%0d expected no pulse", cyc);
      end else begin
        f = fd_q.pop_front();
        if (cyc != f) begin
          failures++;
          $display("[TB] FAIL frame_done cyc=%0d expected cyc=%0d", cyc, f);
        end
      end
    end
  end

  // Watchdog: the run is far shorter than this bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish, cyc=%0d expected under 20000", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int t0;
    int t1;
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef CURSOR_HL_EN
    cx = 3'd7;
    cy = 3'd7;
`endif
    init_board();
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    check_reset_state("reset");

    // Full frame, no stalls; en_plot dropped during the last cell.
    $display("[TB] full frame");
    en_count = 0;
    start_frame(t0);
    for (int i = 0; i < 64; i++) push_cell(i, t0 + PACE + 3 + (PACE + 4) * i);
    fd_q.push_back(t0 + 64 * (PACE + 4));
    wait_cyc(t0 + 380);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cyc(t0 + 390);
    checkOutput("frame_enable_count", en_count, 64);
    checkOutput("frame_idle_busy", int'(busy), 0);
    finish_test("frame");

    // board_busy stall of 10 cycles while cell 5 is addressed.
    $display("[TB] board_busy stall");
    apply_reset();
    start_frame(t0);
    for (int i = 0; i < 5; i++) push_cell(i, t0 + 5 + 6 * i);
    for (int i = 5; i < 8; i++) push_cell(i, t0 + 15 + 6 * i);
    wait_cyc(t0 + 30);
    applyStimulus(1'b1, 1'b1, 1'b1);
    wait_cyc(t0 + 35);
    checkOutput("stall_rd_x", int'(rd_x), 5);
    checkOutput("stall_rd_y", int'(rd_y), 0);
    checkOutput("stall_busy", int'(busy), 1);
    wait_cyc(t0 + 40);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_cyc(t0 + 60);
    finish_test("stall");

    // plot_ready low for 7 cycles while cell 0 is in PLOT.
    $display("[TB] plot_ready backpressure");
    apply_reset();
    board[0] = 2'b11;
    start_frame(t0);
    push_cell(0, t0 + 12);
    push_cell(1, t0 + 18);
    push_cell(2, t0 + 24);
    wait_cyc(t0 + 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_cyc(t0 + 7);
    board[0] = 2'b01;
    checkOutput("ready_select_held", int'(select), 3);
    checkOutput("ready_enable_low", int'(enable), 0);
    wait_cyc(t0 + 11);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_cyc(t0 + 26);
    finish_test("ready");
    apply_reset();
    board[0] = 2'b00;

    // en_plot dropped while cell 20 waits on its pace counter.
    $display("[TB] en_plot drop");
    start_frame(t0);
    for (int i = 0; i <= 20; i++) push_cell(i, t0 + 5 + 6 * i);
    wait_cyc(t0 + 122);
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_cyc(t0 + 127);
    checkOutput("drop_busy", int'(busy), 0);
    checkOutput("drop_rd_x", int'(rd_x), 0);
    checkOutput("drop_rd_y", int'(rd_y), 0);
    checkOutput("drop_x_hold", int'(x_plot), 61);
    checkOutput("drop_y_hold", int'(y_plot), 35);
    checkOutput("drop_select_hold", int'(select), exp_sel(20));
    wait_cyc(t0 + 135);
    finish_test("drop");

    // Single-cycle reset in the middle of cell 40, then a fresh start.
    $display("[TB] mid-frame reset");
    start_frame(t0);
    for (int i = 0; i < 40; i++) push_cell(i, t0 + 5 + 6 * i);
    wait_cyc(t0 + 242);
    applyStimulus(1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0;
    check_reset_state("midreset");
    wait_cyc(t0 + 250);
    start_frame(t1);
    push_cell(0, t1 + 5);
    push_cell(1, t1 + 11);
    wait_cyc(t1 + 14);
    finish_test("restart");
    apply_reset();

`ifdef CURSOR_HL_EN
    // Cursor on an empty cell highlights; on an occupied cell it does not.
    $display("[TB] cursor highlight");
    cx = 3'd2;
    cy = 3'd2;
    start_frame(t0);
    for (int i = 0; i <= 18; i++) push_cell(i, t0 + 5 + 6 * i);
    wait_cyc(t0 + 115);
    finish_test("cursor_empty");
    apply_reset();
    cx = 3'd3;
    cy = 3'd3;
    start_frame(t0);
    for (int i = 0; i <= 27; i++) push_cell(i, t0 + 5 + 6 * i);
    wait_cyc(t0 + 169);
    checkOutput("cursor_occupied_select", int'(select), 2);
    finish_test("cursor_occupied");
    apply_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
